// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register and its bench.
// Mode encodings select hold / shift right / shift left / parallel load.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage : usr_pkg

// File: rtl/usr_seq_counter.sv
// Shift-sequence tracker: counts shifts after a load and flags completion.
// busy is high from a load until N counted shifts; done pulses on the N-th.
module usr_seq_counter #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load,
    input  logic shift,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next-state: load restarts the sequence and wins over counting.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (en) begin
            if (load) begin
                cnt_d  = '0;
                busy_d = 1'b1;
            end else if (shift && busy_q) begin
                if (cnt_q == LAST) begin
                    cnt_d  = '0;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // Tracker state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule : usr_seq_counter

// File: rtl/univ_shift_reg.sv
// N-bit universal shift register (PIPO/SIPO/PISO/SISO by mode) with a
// shift-sequence tracker. Optional macro USR_ROTATE_EN adds the rot input,
// turning shifts into rotations while rot=1.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [1:0]   mode,
    input  logic [N-1:0] pin,
    input  logic         sin_r,
    input  logic         sin_l,
`ifdef USR_ROTATE_EN
    input  logic         rot,
`endif
    output logic [N-1:0] q,
    output logic         sout_r,
    output logic         sout_l,
    output logic         busy,
    output logic         done
);

    logic [N-1:0] q_q, q_d;
    logic         fill_r, fill_l;
    logic         load, shift;

    // Bits entering on a shift: serial inputs, or the wrapped-around end bit.
    always_comb begin
`ifdef USR_ROTATE_EN
        fill_r = rot ? q_q[0]   : sin_r;
        fill_l = rot ? q_q[N-1] : sin_l;
`else
        fill_r = sin_r;
        fill_l = sin_l;
`endif
    end

    // Data-path mode multiplexer.
    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode)
                MODE_SHR:  q_d = {fill_r, q_q[N-1:1]};
                MODE_SHL:  q_d = {q_q[N-2:0], fill_l};
                MODE_LOAD: q_d = pin;
                default:   q_d = q_q;
            endcase
        end
    end

    // Data register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign load  = (mode == MODE_LOAD);
    assign shift = (mode == MODE_SHR) || (mode == MODE_SHL);

    usr_seq_counter #(
        .N(N)
    ) u_seq (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .load (load),
        .shift(shift),
        .busy (busy),
        .done (done)
    );

    assign q      = q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[N-1];

endmodule : univ_shift_reg
